nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Sequencer that drives the frequency-control inputs of the NCO sine generator. It steps the 32-bit frequency word linearly from a start value to a stop value with a programmable dwell per step, in single-shot or continuous mode. It also forwards the registered test-tone offset/enable field. It sits between the host configuration registers and the NCO, replacing a static frequency word with a scheduled sweep.

## Interface
- `FW_W`, default 32: frequency word width.
- `DWELL_W`, default 16: dwell counter width.
- `CNT_W`, default 16: step counter width.
- `clk` in 1: system clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `abort` in 1: stop the sweep immediately; honoured in any non-IDLE state.
- `mode_cont` in 1: 1 = restart at the start word after stop, 0 = single shot.
- `cfg_start_word` in FW_W: first frequency word.
- `cfg_stop_word` in FW_W: last permitted frequency word, inclusive.
- `cfg_step_word` in FW_W: increment per step.
- `cfg_dwell` in DWELL_W: the number of cycles each word is held is `cfg_dwell + 1`.
- `cfg_test_offset` in 14: test-tone offset field.
- `cfg_test_en` in 1: test-tone enable.
- `freq_word` out FW_W: registered NCO frequency word.
- `nco_test` out 15: registered `{cfg_test_offset, cfg_test_en}`.
- `step_strobe` out 1: one-cycle pulse, high in the first cycle each new `freq_word` value is presented.
- `busy` out 1: high in LOAD and DWELL.
- `done` out 1: one-cycle pulse when a single-shot sweep completes.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `step_cnt` out CNT_W: number of `freq_word` values presented since the last accepted `start`; saturates at all-ones.

## Operation
- **Reset**: all outputs are 0 and the state is IDLE.
- **States**:
  - IDLE: waits for `start`.
  - LOAD: captures the configuration.
  - DWELL: counts down the hold time for the current word.
  - DONE: emits the completion pulse.
- **IDLE**:
  - If `start && !abort`, the request is checked first.
  - If `cfg_step_word == 0` or `cfg_start_word > cfg_stop_word`, the request is rejected: `cfg_err` pulses and the state stays IDLE.
  - Otherwise the state goes to LOAD.
  - If `start && abort` arrive together, the request is ignored and no `cfg_err` is raised.
- **LOAD**:
  - Shadows start, stop, step, dwell and `mode_cont`; later changes on the `cfg_*` sweep inputs have no effect until the next `start`.
  - Sets `freq_word <= start`, `dwell_cnt <= dwell`, `step_cnt <= 1`, and pulses `step_strobe`.
  - Goes to DWELL.
- **DWELL**:
  - `abort` takes priority: go to IDLE, `freq_word` holds its current value, no `done` pulse.
  - Else if `dwell_cnt != 0`, decrement it.
  - Else compute `nxt = freq_word + step` as a 33-bit sum.
  - If `nxt` overflows or `nxt > stop`:
    - with `mode_cont`: `freq_word <= start`, reload `dwell_cnt`, `step_strobe`, `step_cnt++` (saturating);
    - otherwise go to DONE with `freq_word` held.
  - Otherwise: `freq_word <= nxt[FW_W-1:0]`, reload `dwell_cnt`, `step_strobe`, `step_cnt++` (saturating).
- **DONE**: `done` pulses for one cycle and the state returns to IDLE; `freq_word` holds the last word.
- **`nco_test`**: registered from `{cfg_test_offset, cfg_test_en}` every cycle, independent of the state machine. It is 0 in reset.
- **`start` while busy**: ignored, with no `cfg_err`.

## Timing
- `start` sampled at edge E0: LOAD at E1.
- `freq_word == start` and `step_strobe == 1` in the cycle after E1.
- Each word is held for exactly `dwell + 1` cycles, with `step_strobe` high in the first of them.
- Single shot: `done` is high in the cycle immediately after the last word's final hold cycle.
- `abort` sampled at edge Ea: `busy == 0` after Ea, and the abort edge itself does not change `freq_word`.
- Synchronous reset mid-sweep: all outputs return to 0 at the next edge.
- The downstream NCO adds its own register stage on the phase increment; that latency is not compensated here.

## Structure
- Package `nco_ctrl_pkg`:
  - state enum (IDLE, LOAD, DWELL, DONE);
  - default widths FW_W, DWELL_W, CNT_W;
  - constant `NCO_TEST_W = 15`.
- One sub-module, `nco_dwell_timer`: a loadable down-counter with a zero flag, reload and enable inputs, and the synchronous active-low `rst`.

## Test plan
- **Single sweep**: start=0x1000_0000, stop=0x1000_0300, step=0x100, dwell=2 → words 0x1000_0000, 0x1000_0100, 0x1000_0200, 0x1000_0300, each held 3 cycles; 4 `step_strobe` pulses; `done` one cycle after the 12th word cycle; `step_cnt == 4`.
- **Continuous**: same configuration with `mode_cont == 1` → after 0x1000_0300 the word returns to 0x1000_0000 and `step_strobe` pulses; no `done` pulse; `step_cnt == 5` at the wrap.
- **Overflow**: start=0xFFFF_FF00, stop=0xFFFF_FFFF, step=0x80, dwell=0 → words 0xFFFF_FF00, 0xFFFF_FF80, then `done`; the word never wraps to a low value.
- **Rejects**: step=0 → `cfg_err` for one cycle, `busy == 0`. start=5, stop=4 → `cfg_err` for one cycle. `start` while busy → ignored, no `cfg_err`.
- **Abort and reset**:
  - `abort` during the second word → `busy` drops, `freq_word` stays 0x1000_0100, no `done`.
  - `rst == 0` mid-sweep → all outputs 0 at the next edge.
- **`nco_test`**: offset=0x1ABC, en=1 → `nco_test == 0x3579` one cycle later, unaffected by sweep activity.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep controller.
// State encoding, default widths and the test-field width.
package nco_ctrl_pkg;

  localparam int FW_W_DEF    = 32;
  localparam int DWELL_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int NCO_TEST_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter holding each sweep word for its dwell time.
// Ports: clk, rst (sync, active low), load/load_val, en, zero flag.
module nco_dwell_timer
  import nco_ctrl_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-word sweep sequencer feeding the NCO.
// Ports: clk, rst (sync, active low), start/abort, cfg_* sweep setup,
// freq_word, nco_test, step_strobe, busy, done, cfg_err, step_cnt.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int FW_W    = FW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode_cont,
  input  logic [FW_W-1:0]       cfg_start_word,
  input  logic [FW_W-1:0]       cfg_stop_word,
  input  logic [FW_W-1:0]       cfg_step_word,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic [13:0]           cfg_test_offset,
  input  logic                  cfg_test_en,
  output logic [FW_W-1:0]       freq_word,
  output logic [NCO_TEST_W-1:0] nco_test,
  output logic                  step_strobe,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      step_cnt
);

  state_t             state;
  logic [FW_W-1:0]    s_start;
  logic [FW_W-1:0]    s_stop;
  logic [FW_W-1:0]    s_step;
  logic [DWELL_W-1:0] s_dwell;
  logic               s_cont;

  logic               tmr_zero;
  logic               tmr_load;
  logic               tmr_en;
  logic [FW_W:0]      nxt;
  logic               past_stop;
  logic               cfg_bad;
  logic [CNT_W-1:0]   cnt_inc;

  // Carry out of the sum counts as running past the stop word.
  assign nxt       = {1'b0, freq_word} + {1'b0, s_step};
  assign past_stop = nxt[FW_W] || (nxt[FW_W-1:0] > s_stop);
  assign cfg_bad   = (cfg_step_word == '0) ||
                     (cfg_start_word > cfg_stop_word);
  assign cnt_inc   = (&step_cnt) ? step_cnt : step_cnt + 1'b1;

  assign tmr_en   = (state == ST_DWELL) && !abort;
  assign tmr_load = ((state == ST_LOAD) && !abort) ||
                    (tmr_en && tmr_zero && (!past_stop || s_cont));

  assign busy = (state == ST_LOAD) || (state == ST_DWELL);

  nco_dwell_timer #(
    .W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (s_dwell),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      s_start     <= '0;
      s_stop      <= '0;
      s_step      <= '0;
      s_dwell     <= '0;
      s_cont      <= 1'b0;
      freq_word   <= '0;
      nco_test    <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      step_cnt    <= '0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      nco_test    <= {cfg_test_offset, cfg_test_en};
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              s_start <= cfg_start_word;
              s_stop  <= cfg_stop_word;
              s_step  <= cfg_step_word;
              s_dwell <= cfg_dwell;
              s_cont  <= mode_cont;
              state   <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            freq_word   <= s_start;
            step_cnt    <= CNT_W'(1);
            step_strobe <= 1'b1;
            state       <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (tmr_zero) begin
            if (!past_stop) begin
              freq_word   <= nxt[FW_W-1:0];
              step_strobe <= 1'b1;
              step_cnt    <= cnt_inc;
            end else if (s_cont) begin
              freq_word   <= s_start;
              step_strobe <= 1'b1;
              step_cnt    <= cnt_inc;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl with a list-based sweep model.
// Expected strobe/done/err events are queued by the driver, popped by a monitor.
module tb_nco_sweep_ctrl;

  localparam int CW  = 3;
  localparam int SAT = 7;
  localparam int K_STEP = 4;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode_cont;
  logic [31:0] cfg_start_word;
  logic [31:0] cfg_stop_word;
  logic [31:0] cfg_step_word;
  logic [15:0] cfg_dwell;
  logic [13:0] cfg_test_offset;
  logic        cfg_test_en;
  logic [31:0] freq_word;
  logic [14:0] nco_test;
  logic        step_strobe;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [CW-1:0] step_cnt;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] word;
    int          cnt;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  nco_sweep_ctrl #(
    .FW_W    (32),
    .DWELL_W (16),
    .CNT_W   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .mode_cont       (mode_cont),
    .cfg_start_word  (cfg_start_word),
    .cfg_stop_word   (cfg_stop_word),
    .cfg_step_word   (cfg_step_word),
    .cfg_dwell       (cfg_dwell),
    .cfg_test_offset (cfg_test_offset),
    .cfg_test_en     (cfg_test_en),
    .freq_word       (freq_word),
    .nco_test        (nco_test),
    .step_strobe     (step_strobe),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .step_cnt        (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  function automatic void push(input int k, input int c,
                               input logic [31:0] w,
                               input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.word = w;
    e.cnt  = n;
    q.push_back(e);
  endfunction

  // Monitor: nco_test pipeline plus event scoreboard.
  always @(posedge clk) begin
    logic [14:0] exp_t;
    logic [2:0]  flags;
    ev_t         e;
    exp_t = rst ? {cfg_test_offset, cfg_test_en} : 15'd0;
    #1;
    cyc++;
    chk("nco_test", 64'(nco_test), 64'(exp_t));
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_event: got none expected kind %0d at cyc %0d",
               q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    flags = {step_strobe, done, cfg_err};
    if (flags != 3'b000) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got flags %b expected none at cyc %0d",
                 flags, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_kind", 64'(flags), 64'(e.kind));
        if (e.kind == K_STEP) begin
          chk("step_word", 64'(freq_word), 64'(e.word));
          chk("step_cnt", 64'(step_cnt), 64'(e.cnt));
          chk("step_busy", 64'(busy), 64'd1);
        end else if (e.kind == K_DONE) begin
          chk("done_word", 64'(freq_word), 64'(e.word));
          chk("done_cnt", 64'(step_cnt), 64'(e.cnt));
          chk("done_busy", 64'(busy), 64'd0);
        end else begin
          chk("err_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Reference: walk the word list with 64-bit arithmetic; keep
  // only events that land strictly before the abort edge.
  task automatic model(input logic [31:0] s, input logic [31:0] p,
                       input logic [31:0] st, input int d,
                       input bit cont, input int e0, input int ea,
                       output logic [31:0] last, output int endc);
    longint w;
    int     i;
    int     t;
    w    = longint'(s);
    i    = 0;
    t    = e0 + 1;
    last = freq_word;
    endc = t;
    repeat (400) begin
      if (t >= ea) break;
      push(K_STEP, t, w[31:0], sat(i + 1));
      last = w[31:0];
      i++;
      t += d + 1;
      endc = t;
      if (w + longint'(st) > longint'(p)) begin
        if (cont) begin
          w = longint'(s);
        end else begin
          if (t < ea) push(K_DONE, t, last, sat(i));
          break;
        end
      end else begin
        w = w + longint'(st);
      end
    end
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] p,
                     input logic [31:0] st, input int d,
                     input bit cont, input int ab, input bit poke);
    logic [31:0] last;
    int          e0;
    int          ea;
    int          endc;
    bit          bad;
    cfg_start_word  = s;
    cfg_stop_word   = p;
    cfg_step_word   = st;
    cfg_dwell       = 16'(d);
    mode_cont       = cont;
    cfg_test_offset = 14'($urandom);
    cfg_test_en     = 1'($urandom);
    e0  = cyc + 1;
    ea  = (ab > 0) ? e0 + ab : 32'h3fff_ffff;
    bad = (st == 0) || (s > p);
    if (bad) begin
      push(K_ERR, e0, 32'd0, 0);
    end else begin
      model(s, p, st, d, cont, e0, ea, last, endc);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (bad) begin
      repeat (2) @(negedge clk);
      chk("drain_err", 64'(q.size()), 64'd0);
      return;
    end
    @(negedge clk);
    cfg_start_word = $urandom;
    cfg_stop_word  = $urandom;
    cfg_step_word  = $urandom;
    cfg_dwell      = 16'($urandom);
    mode_cont      = 1'($urandom);
    if (poke) start = 1'b1;
    while (cyc < endc + 2 && cyc < ea + 2) begin
      if (cyc == ea - 1) abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (cyc == ea) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_word", 64'(freq_word), 64'(last));
      end
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int          e0;
    int          endc;
    logic [31:0] last;
    logic [31:0] s;
    logic [31:0] st;
    longint      p;
    int          k;
    int          sel;

    rst             = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    mode_cont       = 1'b0;
    cfg_start_word  = '0;
    cfg_stop_word   = '0;
    cfg_step_word   = '0;
    cfg_dwell       = '0;
    cfg_test_offset = 14'h2AAA;
    cfg_test_en     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_freq", 64'(freq_word), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobe", 64'(step_strobe), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_cnt", 64'(step_cnt), 64'd0);
    chk("rst_test", 64'(nco_test), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    cfg_test_offset = 14'h1ABC;
    cfg_test_en     = 1'b1;
    @(negedge clk);
    chk("nco_test_3579", 64'(nco_test), 64'h3579);

    run(32'h1000_0000, 32'h1000_0300, 32'h100, 2, 0, 0, 0);
    run(32'h1000_0000, 32'h1000_0300, 32'h100, 2, 1, 26, 0);
    run(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 0, 0, 0, 0);
    run(32'h1000_0000, 32'h1000_0300, 32'h0, 2, 0, 0, 0);
    run(32'd5, 32'd4, 32'h1, 2, 0, 0, 0);
    run(32'h1000_0000, 32'h1000_0300, 32'h100, 2, 0, 0, 1);
    run(32'h1000_0000, 32'h1000_0300, 32'h100, 2, 0, 5, 0);
    chk("abort_2nd", 64'(freq_word), 64'h1000_0100);

    cfg_start_word = 32'h1000_0000;
    cfg_step_word  = 32'h100;
    cfg_stop_word  = 32'h1000_0300;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_abort_busy", 64'(busy), 64'd0);

    cfg_dwell = 16'd3;
    mode_cont = 1'b0;
    e0 = cyc + 1;
    model(32'h1000_0000, 32'h1000_0300, 32'h100, 3, 0,
          e0, 32'h3fff_ffff, last, endc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 5) @(negedge clk);
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_freq", 64'(freq_word), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_strobe", 64'(step_strobe), 64'd0);
    chk("mid_rst_cnt", 64'(step_cnt), 64'd0);
    chk("mid_rst_test", 64'(nco_test), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      st  = $urandom_range(1, 32'h0010_0000);
      k   = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) begin
        s = 32'hFFFF_FFFF - $urandom_range(0, 32'h0040_0000);
      end else begin
        s = $urandom;
      end
      p = longint'(s) + longint'(st) * (k - 1) +
          longint'($urandom_range(0, int'(st) - 1));
      if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
      if (sel == 0) begin
        run(s, p[31:0], 32'd0, 1, 0, 0, 0);
      end else if (sel == 1) begin
        if (s == 0) s = 1;
        run(s, s - 1, st, 1, 0, 0, 0);
      end else if (sel < 5) begin
        run(s, p[31:0], st, $urandom_range(0, 3), 1,
            $urandom_range(2, 40), sel[0]);
      end else if (sel < 7) begin
        run(s, p[31:0], st, $urandom_range(0, 3), 0,
            $urandom_range(2, 12), 0);
      end else begin
        run(s, p[31:0], st, $urandom_range(0, 3), 0, 0, sel[0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
